sseg4_scan: RTL

- Time-multiplexed driver for the 4-digit common-anode seven-segment display.
- Sits directly downstream of the bcd11 converter and replaces the static mux2_4b plus fixed-anode scheme: all four BCD digits are shown at once by cycling the anodes.
- Consumes the four BCD nibbles and per-digit decimal-point requests.
- Produces registered, active-low seg/dp/an for the board pins.

---
 rtl/sseg_pkg.sv | 33 +++
 rtl/sseg_decoder.sv | 14 +
 rtl/sseg4_scan.sv | 94 +++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared types, constants and hex-to-segment table for the seven-segment stage
package sseg_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Active-low segments, bit order {g,f,e,d,c,b,a}; 10-15 show hex glyphs
    function automatic logic [6:0] hex_to_seg(input bcd_t num);
        logic [6:0] s;
        case (num)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sseg_decoder.sv
// rtl/sseg_decoder.sv - combinational hex nibble to active-low seven-segment decoder
module sseg_decoder
    import sseg_pkg::*;
(
    input  logic [3:0] num,
    output logic [6:0] sseg
);

    // Pure table lookup, shared with anything else that imports the package
    always_comb begin
        sseg = hex_to_seg(bcd_t'(num));
    end

endmodule

// File: rtl/sseg4_scan.sv
// rtl/sseg4_scan.sv - 4-digit multiplexed seven-segment scanner; SSEG_LZB_EN enables leading-zero blanking
module sseg4_scan
    import sseg_pkg::*;
#(
    parameter int REFRESH_BITS = 17,
    parameter int DEAD_CYCLES  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int SUB_W = REFRESH_BITS - 2;
    localparam logic [SUB_W-1:0] DEAD_W = DEAD_CYCLES[SUB_W-1:0];

    logic [REFRESH_BITS-1:0] cnt;
    logic [1:0]              slot;
    logic [SUB_W-1:0]        sub;
    bcd_t                    nibble;
    logic [6:0]              seg_dec;
    logic                    dead;
    logic                    blank;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [3:0]              an_d;

    assign slot   = cnt[REFRESH_BITS-1 -: 2];
    assign sub    = cnt[SUB_W-1:0];
    assign nibble = digits[{slot, 2'b00} +: 4];
    assign dead   = (sub < DEAD_W);

`ifdef SSEG_LZB_EN
    logic lzb;

    // A digit is suppressed when it and every more significant digit are zero
    always_comb begin
        lzb = 1'b0;
        case (slot)
            2'd3:    lzb = (digits[15:12] == 4'd0);
            2'd2:    lzb = (digits[15:8]  == 8'd0);
            2'd1:    lzb = (digits[15:4]  == 12'd0);
            default: lzb = 1'b0;
        endcase
    end

    assign blank = dead | lzb;
`else
    assign blank = dead;
`endif

    sseg_decoder u_decoder (
        .num  (nibble),
        .sseg (seg_dec)
    );

    // Free-running scan counter; top bits pick the digit, low bits time the slot
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next pin values: all-off during dead time or blanking, else the selected digit
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(4'b0001 << slot);
            seg_d = seg_dec;
            dp_d  = ~dp_in[slot];
        end
    end

    // Registered pins so the board sees glitch-free anode switching
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule
